writeback_cycle: RTL
====================

// Module: writeback_cycle
// PURPOSE
//  Final pipeline stage: drives rf_writeback_enable/addr/data into decodeCycle's register file.
//  Consumes the write intent (rf_write_enable/addr/data_sel, dm_load_type) produced at decode.
//  Selects the ALU result, aligned/extended load data or PC+4, and holds the stage while a load
//  completes. Issues the single registered register-file write per retired instruction.
// PARAMETERS
//  XLEN           32  datapath width
//  REGISTER_SIZE  5   register address width
//  FUNCT3_SIZE    3   load-type code width
// PORTS
//  clk                  in   1      clock, rising edge
//  rst                  in   1      async active-high reset
//  wb_valid_in          in   1      upstream instruction valid this cycle
//  wb_ready_out         out  1      stage can accept (low = stall upstream)
//  rf_write_enable      in   1      instruction writes rd
//  rf_write_addr        in   REGISTER_SIZE  rd
//  rf_write_data_sel    in   2      00 ALU, 01 load data, 10 PC+4, 11 reserved
//  alu_result           in   XLEN   ALU output (also load address for loads)
//  PC_in                in   XLEN   PC of the instruction
//  dm_load_type         in   FUNCT3_SIZE  000 LB,001 LH,010 LW,100 LBU,101 LHU
//  dm_read_data         in   XLEN   word-aligned memory read data
//  dm_read_valid        in   1      dm_read_data valid this cycle
//  rf_writeback_enable  out  1      register-file write strobe
//  rf_writeback_addr    out  REGISTER_SIZE  write address
//  rf_writeback_data    out  XLEN   write data
//  load_misaligned      out  1      1-cycle pulse: misaligned load dropped
// BEHAVIOUR
//  - Reset (async): state=IDLE; wb_ready_out=1; rf_writeback_enable=0, addr=0, data=0,
//    load_misaligned=0. Reset mid-load abandons the load; no write is issued.
//  - Accept = wb_valid_in & wb_ready_out. Fields are captured only on accept.
//  - wb_ready_out = (state==IDLE), combinational from state.
//  - Non-load accept (sel 00/10): rf_writeback_* is registered and valid on the next edge.
//    Latency is 1 cycle. sel 10 data = PC_in + 4, mod 2^XLEN (wraps).
//  - Load accept (sel 01): if dm_read_valid is high in the same cycle, complete as non-load.
//    Otherwise go to WAIT_LOAD, capture alu_result[1:0] and load type, hold ready low.
//    dm_read_valid in WAIT_LOAD -> write on the next edge; return to IDLE on that same edge.
//  - FSM: IDLE -(load accept, !dm_read_valid)-> WAIT_LOAD -(dm_read_valid)-> IDLE. No timeout.
//  - Alignment: byte = word >> (8*addr[1:0]); half = word >> (16*addr[1]).
//    LB/LH sign-extend; LBU/LHU zero-extend; LW passes through.
//  - Misaligned (LH/LHU addr[0]=1, LW addr[1:0]!=0): no write; load_misaligned pulses on the
//    completion edge.
//  - Suppressed writes: rf_write_enable=0, rd=0, sel=11, or an undefined load type
//    (011,110,111). Enable stays 0. The instruction still retires in the same cycle count.
//  - rf_writeback_enable is high exactly one cycle per retiring write. Addr/data hold their
//    last values while enable is low.
//  - dm_read_valid in IDLE with no load accept: ignored.
// STRUCTURE
//  - riscv_pkg: wb_sel_t enum (WB_ALU, WB_MEM, WB_PC4, WB_RSVD); load funct3 localparams
//    (LB, LH, LW, LBU, LHU); wb_state_t enum (IDLE, WAIT_LOAD).
//  - Sub-module load_align (combinational): word, addr[1:0], type -> data, misaligned.
//  - Top level holds the FSM, capture registers and output registers.
// TESTING
//  1. ADD-type: sel=00, rd=5, alu=32'h1234 -> next cycle enable=1, addr=5, data=32'h1234, ready stays 1.
//  2. JAL: sel=10, PC_in=32'hFFFF_FFFC -> data=32'h0000_0000 (wrap); rd=0 variant -> enable stays 0.
//  3. LB: addr[1:0]=3, word=32'h80FF_0000, valid 3 cycles late -> ready=0 for 3 cycles, then data=32'hFFFF_FF80.
//     LBU on the same word -> data=32'h80.
//  4. LH: addr[1:0]=1 -> enable=0, load_misaligned one-cycle pulse.
//     LHU addr=2, word=32'h8001_xxxx -> data=32'h8001.
//  5. Back-to-back: load with same-cycle valid, then ALU op -> two consecutive enable cycles, ready never low.
//  6. rst asserted during WAIT_LOAD -> outputs zero immediately; later dm_read_valid -> no write.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared writeback types: result select, load funct3 codes, stage FSM state.
// Imported by the writeback stage and its load alignment helper.
package riscv_pkg;

    typedef enum logic [1:0] {
        WB_ALU  = 2'b00,
        WB_MEM  = 2'b01,
        WB_PC4  = 2'b10,
        WB_RSVD = 2'b11
    } wb_sel_t;

    localparam logic [2:0] LB  = 3'b000;
    localparam logic [2:0] LH  = 3'b001;
    localparam logic [2:0] LW  = 3'b010;
    localparam logic [2:0] LBU = 3'b100;
    localparam logic [2:0] LHU = 3'b101;

    typedef enum logic {
        IDLE,
        WAIT_LOAD
    } wb_state_t;

endpackage

// File: rtl/load_align.sv
// Extracts and extends a byte/half/word from a word-aligned memory read.
// Flags misaligned halves/words and undefined load types.
module load_align
    import riscv_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter int FUNCT3_SIZE = 3
) (
    input  logic [XLEN-1:0]        word_i,
    input  logic [1:0]             offset_i,
    input  logic [FUNCT3_SIZE-1:0] type_i,
    output logic [XLEN-1:0]        data_o,
    output logic                   misaligned_o,
    output logic                   type_ok_o
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;

    assign byte_v = 8'(word_i >> {offset_i, 3'b000});
    assign half_v = 16'(word_i >> {offset_i[1], 4'b0000});

    // Select and extend the addressed lane by load type
    always_comb begin
        data_o       = '0;
        misaligned_o = 1'b0;
        type_ok_o    = 1'b1;
        unique case (type_i)
            LB:  data_o = {{(XLEN-8){byte_v[7]}}, byte_v};
            LBU: data_o = {{(XLEN-8){1'b0}}, byte_v};
            LH: begin
                data_o       = {{(XLEN-16){half_v[15]}}, half_v};
                misaligned_o = offset_i[0];
            end
            LHU: begin
                data_o       = {{(XLEN-16){1'b0}}, half_v};
                misaligned_o = offset_i[0];
            end
            LW: begin
                data_o       = word_i;
                misaligned_o = (offset_i != 2'b00);
            end
            default: type_ok_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/writeback_cycle.sv
// Final pipeline stage: picks ALU / load / PC+4 result and issues one
// registered register-file write per retired instruction, stalling on loads.
module writeback_cycle
    import riscv_pkg::*;
#(
    parameter int XLEN          = 32,
    parameter int REGISTER_SIZE = 5,
    parameter int FUNCT3_SIZE   = 3
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wb_valid_in,
    output logic                     wb_ready_out,
    input  logic                     rf_write_enable,
    input  logic [REGISTER_SIZE-1:0] rf_write_addr,
    input  logic [1:0]               rf_write_data_sel,
    input  logic [XLEN-1:0]          alu_result,
    input  logic [XLEN-1:0]          PC_in,
    input  logic [FUNCT3_SIZE-1:0]   dm_load_type,
    input  logic [XLEN-1:0]          dm_read_data,
    input  logic                     dm_read_valid,
    output logic                     rf_writeback_enable,
    output logic [REGISTER_SIZE-1:0] rf_writeback_addr,
    output logic [XLEN-1:0]          rf_writeback_data,
    output logic                     load_misaligned
);

    wb_state_t                state_q;
    logic                     we_q;
    logic [REGISTER_SIZE-1:0] rd_q;
    logic [1:0]               off_q;
    logic [FUNCT3_SIZE-1:0]   lt_q;

    logic                     wb_en_q, mis_q;
    logic [REGISTER_SIZE-1:0] wb_addr_q;
    logic [XLEN-1:0]          wb_data_q;

    wb_sel_t                  sel;
    logic                     idle, accept, done, is_load;
    logic                     we_in, we_d, mis_d, park;
    logic [REGISTER_SIZE-1:0] rd_d;
    logic [XLEN-1:0]          data_d;
    logic [1:0]               off;
    logic [FUNCT3_SIZE-1:0]   lt;
    logic [XLEN-1:0]          ld_data;
    logic                     ld_mis, ld_ok;

    assign sel          = wb_sel_t'(rf_write_data_sel);
    assign idle         = (state_q == IDLE);
    assign wb_ready_out = idle;
    assign accept       = wb_valid_in & idle;

    // Write intent is qualified once: rd=0 and reserved select never write
    assign we_in = rf_write_enable
                 & (rf_write_addr != '0)
                 & (sel != WB_RSVD);

    // In WAIT_LOAD the aligner works from the captured offset and type
    assign off = idle ? alu_result[1:0] : off_q;
    assign lt  = idle ? dm_load_type : lt_q;

    load_align #(
        .XLEN        (XLEN),
        .FUNCT3_SIZE (FUNCT3_SIZE)
    ) u_load_align (
        .word_i       (dm_read_data),
        .offset_i     (off),
        .type_i       (lt),
        .data_o       (ld_data),
        .misaligned_o (ld_mis),
        .type_ok_o    (ld_ok)
    );

    // Retirement decision and result mux for this cycle
    always_comb begin
        is_load = idle ? (sel == WB_MEM) : 1'b1;
        park    = accept & (sel == WB_MEM) & ~dm_read_valid;
        done    = (accept & ~park) | (~idle & dm_read_valid);
        rd_d    = idle ? rf_write_addr : rd_q;
        we_d    = done & (idle ? we_in : we_q);
        mis_d   = done & is_load & ld_ok & ld_mis;
        if (is_load) begin
            we_d = we_d & ld_ok & ~ld_mis;
        end
        if (is_load) begin
            data_d = ld_data;
        end else if (sel == WB_PC4) begin
            data_d = PC_in + XLEN'(4);
        end else begin
            data_d = alu_result;
        end
    end

    // FSM, load capture and registered write port
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            we_q      <= 1'b0;
            rd_q      <= '0;
            off_q     <= '0;
            lt_q      <= '0;
            wb_en_q   <= 1'b0;
            wb_addr_q <= '0;
            wb_data_q <= '0;
            mis_q     <= 1'b0;
        end else begin
            wb_en_q <= we_d;
            mis_q   <= mis_d;
            if (we_d) begin
                wb_addr_q <= rd_d;
                wb_data_q <= data_d;
            end
            case (state_q)
                IDLE: begin
                    if (park) begin
                        state_q <= WAIT_LOAD;
                        we_q    <= we_in;
                        rd_q    <= rf_write_addr;
                        off_q   <= alu_result[1:0];
                        lt_q    <= dm_load_type;
                    end
                end
                WAIT_LOAD: begin
                    if (dm_read_valid) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign rf_writeback_enable = wb_en_q;
    assign rf_writeback_addr   = wb_addr_q;
    assign rf_writeback_data   = wb_data_q;
    assign load_misaligned     = mis_q;

endmodule
